// File: rtl/multi_clock_divider.sv
// Multi-channel programmable clock divider: 50% duty divided clocks plus rise ticks.
// Divisor changes are staged in a shadow register and committed at a half-period boundary.
module multi_clock_divider #(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned CH_SEL_W    = 1,
    parameter int unsigned CNT_WIDTH   = 24,
    parameter int unsigned DEFAULT_DIV = 5999999
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    en,
    input  logic                 sync,
    input  logic                 div_wr,
    input  logic [CH_SEL_W-1:0]  div_ch,
    input  logic [CNT_WIDTH-1:0] div_val,
    output logic [NUM_CH-1:0]    out_clk,
    output logic [NUM_CH-1:0]    out_tick
);

    localparam logic [CNT_WIDTH-1:0] DEF_D = CNT_WIDTH'(DEFAULT_DIV);

    logic wr_valid_c;
    assign wr_valid_c = div_wr && (32'(div_ch) < NUM_CH);

    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
        logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
        logic [CNT_WIDTH-1:0] act_q, act_d;
        logic [CNT_WIDTH-1:0] shadow_q, shadow_d;
        logic                 pend_q, pend_d;
        logic                 first_q, first_d;
        logic                 clk_q, clk_d;
        logic                 tick_q, tick_d;

        logic                 wr_hit_c;
        logic [CNT_WIDTH-1:0] shadow_nxt_c;
        logic                 pend_nxt_c;
        logic [CNT_WIDTH-1:0] d_eff_c;

        // A write landing this cycle is visible to sync, re-enable and wrap commits.
        assign wr_hit_c     = wr_valid_c && (div_ch == CH_SEL_W'(g));
        assign shadow_nxt_c = wr_hit_c ? div_val : shadow_q;
        assign pend_nxt_c   = wr_hit_c | pend_q;
        assign d_eff_c      = (first_q && pend_nxt_c) ? shadow_nxt_c : act_q;

        always_comb begin
            cnt_d    = cnt_q;
            act_d    = act_q;
            shadow_d = shadow_nxt_c;
            pend_d   = pend_nxt_c;
            first_d  = first_q;
            clk_d    = clk_q;
            tick_d   = 1'b0;
            if (sync) begin
                cnt_d   = '0;
                clk_d   = 1'b0;
                first_d = 1'b0;
                if (pend_nxt_c) begin
                    act_d  = shadow_nxt_c;
                    pend_d = 1'b0;
                end
            end else if (!en[g]) begin
                cnt_d   = '0;
                clk_d   = 1'b0;
                first_d = 1'b1;
            end else begin
                first_d = 1'b0;
                if (first_q && pend_nxt_c) begin
                    act_d  = shadow_nxt_c;
                    pend_d = 1'b0;
                end
                if (cnt_q == d_eff_c) begin
                    cnt_d  = '0;
                    clk_d  = ~clk_q;
                    tick_d = ~clk_q;
                    if (pend_nxt_c) begin
                        act_d  = shadow_nxt_c;
                        pend_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q    <= '0;
                act_q    <= DEF_D;
                shadow_q <= DEF_D;
                pend_q   <= 1'b0;
                first_q  <= 1'b1;
                clk_q    <= 1'b0;
                tick_q   <= 1'b0;
            end else begin
                cnt_q    <= cnt_d;
                act_q    <= act_d;
                shadow_q <= shadow_d;
                pend_q   <= pend_d;
                first_q  <= first_d;
                clk_q    <= clk_d;
                tick_q   <= tick_d;
            end
        end

        assign out_clk[g]  = clk_q;
        assign out_tick[g] = tick_q;
    end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Self-checking bench for multi_clock_divider: directed scenarios plus random traffic
// compared cycle by cycle against a half-period countdown model.
module tb_multi_clock_divider;

    localparam int unsigned NUM_CH      = 2;
    localparam int unsigned CH_SEL_W    = 2;
    localparam int unsigned CNT_WIDTH   = 8;
    localparam int unsigned DEFAULT_DIV = 3;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_CH-1:0]    en = '0;
    logic                 sync = 1'b0;
    logic                 div_wr = 1'b0;
    logic [CH_SEL_W-1:0]  div_ch = '0;
    logic [CNT_WIDTH-1:0] div_val = '0;
    logic [NUM_CH-1:0]    out_clk;
    logic [NUM_CH-1:0]    out_tick;

    multi_clock_divider #(
        .NUM_CH(NUM_CH), .CH_SEL_W(CH_SEL_W), .CNT_WIDTH(CNT_WIDTH), .DEFAULT_DIV(DEFAULT_DIV)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .sync(sync), .div_wr(div_wr), .div_ch(div_ch),
        .div_val(div_val), .out_clk(out_clk), .out_tick(out_tick)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int tick_seen [NUM_CH];

    // Model: each channel tracks cycles left in its current half-period.
    int m_left [NUM_CH];   // -1 means freshly enabled / out of reset
    int m_div  [NUM_CH];
    int m_next [NUM_CH];   // -1 means no pending divisor
    bit m_lvl  [NUM_CH];
    bit m_tick [NUM_CH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < int'(NUM_CH); i++) begin
            m_left[i] = -1;
            m_div[i]  = int'(DEFAULT_DIV);
            m_next[i] = -1;
            m_lvl[i]  = 1'b0;
            m_tick[i] = 1'b0;
        end
    endfunction

    function automatic void take_pending(input int i);
        if (m_next[i] >= 0) begin
            m_div[i]  = m_next[i];
            m_next[i] = -1;
        end
    endfunction

    function automatic void model_step();
        if (div_wr && int'(div_ch) < int'(NUM_CH)) m_next[int'(div_ch)] = int'(div_val);
        for (int i = 0; i < int'(NUM_CH); i++) begin
            m_tick[i] = 1'b0;
            if (sync) begin
                m_lvl[i] = 1'b0;
                take_pending(i);
                m_left[i] = m_div[i] + 1;
            end else if (!en[i]) begin
                m_lvl[i]  = 1'b0;
                m_left[i] = -1;
            end else begin
                if (m_left[i] < 0) begin
                    take_pending(i);
                    m_left[i] = m_div[i] + 1;
                end
                m_left[i]--;
                if (m_left[i] == 0) begin
                    m_lvl[i]  = ~m_lvl[i];
                    m_tick[i] = m_lvl[i];
                    take_pending(i);
                    m_left[i] = m_div[i] + 1;
                end
            end
        end
    endfunction

    task automatic cycle();
        logic [NUM_CH-1:0] ec, et;
        @(posedge clk);
        model_step();
        #1;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            ec[i] = m_lvl[i];
            et[i] = m_tick[i];
            if (out_tick[i]) tick_seen[i]++;
        end
        check("out_clk", 32'(out_clk), 32'(ec));
        check("out_tick", 32'(out_tick), 32'(et));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic write_div(input int ch, input int val);
        div_wr  = 1'b1;
        div_ch  = CH_SEL_W'(ch);
        div_val = CNT_WIDTH'(val);
        cycle();
        div_wr  = 1'b0;
    endtask

    task automatic pulse_sync();
        sync = 1'b1;
        cycle();
        sync = 1'b0;
    endtask

    // Asynchronous reset pulse entirely between clock edges.
    task automatic mid_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("rst_clk", 32'(out_clk), 32'd0);
        check("rst_tick", 32'(out_tick), 32'd0);
        #1 rst = 1'b0;
    endtask

    initial begin
        model_reset();
        #1;
        check("reset_clk", 32'(out_clk), 32'd0);
        check("reset_tick", 32'(out_tick), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        en  = 2'b11;
        rst = 1'b0;

        // Default divisor: three rises in 24 cycles on both channels.
        tick_seen[0] = 0;
        tick_seen[1] = 0;
        run(24);
        check("tick_count0", 32'(tick_seen[0]), 32'd3);
        check("tick_count1", 32'(tick_seen[1]), 32'd3);

        // ch1 reprogrammed mid high phase.
        run(1);
        write_div(1, 1);
        run(16);

        // Back-to-back writes to ch0: only the last one lands.
        write_div(0, 0);
        write_div(0, 5);
        run(30);

        // Drifted channels, pending writes, then sync.
        write_div(0, 3);
        run(3);
        write_div(1, 2);
        run(2);
        pulse_sync();
        run(12);

        // Write coincident with sync.
        div_wr = 1'b1; div_ch = 2'd1; div_val = 8'd4; sync = 1'b1;
        cycle();
        div_wr = 1'b0; sync = 1'b0;
        run(12);

        // ch0 disabled for 10 cycles mid-count.
        run(2);
        en = 2'b10;
        run(10);
        en = 2'b11;
        run(14);

        // Reset after programming, then an invalid-channel write.
        write_div(0, 7);
        run(5);
        mid_reset();
        write_div(3, 1);
        tick_seen[0] = 0;
        tick_seen[1] = 0;
        run(23);
        check("post_rst_ticks0", 32'(tick_seen[0]), 32'd3);
        check("post_rst_ticks1", 32'(tick_seen[1]), 32'd3);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            div_wr  = ($urandom_range(7) == 0);
            div_ch  = CH_SEL_W'($urandom_range(3));
            div_val = CNT_WIDTH'($urandom_range(7));
            sync    = ($urandom_range(63) == 0);
            if ($urandom_range(31) == 0) en[$urandom_range(1)] = ~en[$urandom_range(1)];
            cycle();
            if ($urandom_range(499) == 0) mid_reset();
        end
        div_wr = 1'b0;
        sync   = 1'b0;
        run(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
